// File: rtl/display_sched.sv
`default_nettype none
// ============================================================================
// Module      : display_sched
// Description : Round-robin scheduler that picks one of three request sources
//               and holds its 16-bit value on a 4-digit hex display for a
//               minimum dwell time. The shown source may refresh its value
//               while it owns the display.
//               Optional macro DISP_PREEMPT_EN lets source 0 (error/urgent)
//               take over the display from any other source at once.
// Revision    : 1.0 - initial release
// ============================================================================
module display_sched #(
  parameter int DWELL_TICKS = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [47:0] req_data,
  output logic [2:0]  req_ready,
  output logic [15:0] number,
  output logic        number_valid,
  output logic [1:0]  src,
  output logic        busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(DWELL_TICKS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       number_q, number_d;
  logic [1:0]        src_q, src_d;
  logic              nv_q, nv_d;
  logic              busy_q;
  // Index of the source granted most recently; the search starts one above.
  logic [1:0]        last_q, last_d;

  logic [1:0]        w_start;
  logic [1:0]        w_grant_idx;
  logic              w_grant_found;
  logic              w_preempt;

  // Source 0 may steal the display from another source only when enabled.
`ifdef DISP_PREEMPT_EN
  assign w_preempt = (state_q == ST_SHOW) && (src_q != 2'd0) && req_valid[0];
`else
  assign w_preempt = 1'b0;
`endif

  // Round-robin search: first valid source at or above (last + 1) mod 3.
  always_comb begin
    logic [2:0] cand;
    w_grant_idx   = 2'd0;
    w_grant_found = 1'b0;
    cand          = 3'd0;
    w_start       = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    // Walk the order backwards so the earliest candidate overwrites later ones.
    for (int k = 2; k >= 0; k--) begin
      cand = {1'b0, w_start} + 3'(k);
      if (cand >= 3'd3) begin
        cand = cand - 3'd3;
      end
      if (req_valid[cand[1:0]]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = cand[1:0];
      end
    end
  end

  // Next-state, accept handshake and display update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    number_d  = number_q;
    src_d     = src_q;
    nv_d      = nv_q;
    last_d    = last_q;
    req_ready = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (w_grant_found) begin
          req_ready[w_grant_idx] = 1'b1;
          number_d = req_data[{w_grant_idx, 4'b0000} +: 16];
          src_d    = w_grant_idx;
          nv_d     = 1'b1;
          last_d   = w_grant_idx;
          cnt_d    = c_RELOAD;
          state_d  = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (w_preempt) begin
          // Urgent takeover restarts the full dwell regardless of the count.
          req_ready[0] = 1'b1;
          number_d = req_data[15:0];
          src_d    = 2'd0;
          last_d   = 2'd0;
          cnt_d    = c_RELOAD;
          state_d  = ST_SHOW;
        end else if (req_valid[src_q]) begin
          // The owner may refresh its value; the dwell schedule is unchanged.
          req_ready[src_q] = 1'b1;
          number_d = req_data[{src_q, 4'b0000} +: 16];
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (reset) begin
      req_ready = 3'b000;
    end
  end

  // State and display registers with synchronous reset.
  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      number_q <= 16'h0000;
      src_q    <= 2'd0;
      nv_q     <= 1'b0;
      busy_q   <= 1'b0;
      last_q   <= 2'd2;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      number_q <= number_d;
      src_q    <= src_d;
      nv_q     <= nv_d;
      busy_q   <= (state_d == ST_SHOW);
      last_q   <= last_d;
    end
  end

  assign number       = number_q;
  assign number_valid = nv_q;
  assign src          = src_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_display_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_sched
// Description : Scoreboard bench for display_sched. Two instances (dwell 4 and
//               dwell 1) see the same stimulus; a reference model predicts each
//               cycle's handshake and displayed outputs, and a monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_sched;

  logic        clk100 = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [47:0] req_data;

  logic [2:0]  ready_a, ready_b;
  logic [15:0] number_a, number_b;
  logic        nv_a, nv_b;
  logic [1:0]  src_a, src_b;
  logic        busy_a, busy_b;

  always #5 clk100 = ~clk100;

  display_sched #(.DWELL_TICKS(4), .CNT_W(27)) u_dut_a (
    .clk100(clk100), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_a), .number(number_a), .number_valid(nv_a), .src(src_a), .busy(busy_a)
  );

  display_sched #(.DWELL_TICKS(1), .CNT_W(27)) u_dut_b (
    .clk100(clk100), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_b), .number(number_b), .number_valid(nv_b), .src(src_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [2:0]  rdy;
    logic [15:0] num;
    logic        nv;
    logic [1:0]  src;
    logic        busy;
  } obs_t;

  obs_t q_a[$];
  obs_t q_b[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: "showing" flag plus number of display cycles still owed.
  bit          m_show [2];
  int          m_left [2];
  int          m_last [2];
  logic [15:0] m_num  [2];
  bit          m_nv   [2];
  int          m_src  [2];
  int          m_dwell[2];

  task automatic model_reset(input int i);
    m_show[i] = 1'b0;
    m_left[i] = 0;
    m_last[i] = 2;
    m_num[i]  = 16'h0000;
    m_nv[i]   = 1'b0;
    m_src[i]  = 0;
  endtask

  task automatic model_cycle(input int i, input bit r, input logic [2:0] v,
                             input logic [47:0] d, output obs_t e);
    int win;
    int s;
    bit pre;
    e.num  = m_num[i];
    e.nv   = m_nv[i];
    e.src  = 2'(m_src[i]);
    e.busy = m_show[i];
    e.rdy  = 3'b000;
    win = -1;
    pre = 1'b0;
`ifdef DISP_PREEMPT_EN
    pre = m_show[i] && (m_src[i] != 0) && v[0];
`endif
    if (r) begin
      model_reset(i);
    end else if (!m_show[i]) begin
      for (int k = 1; k <= 3; k++) begin
        s = (m_last[i] + k) % 3;
        if (win < 0 && v[s]) win = s;
      end
      if (win >= 0) begin
        e.rdy[win] = 1'b1;
        m_num[i]  = d[16*win +: 16];
        m_src[i]  = win;
        m_nv[i]   = 1'b1;
        m_show[i] = 1'b1;
        m_left[i] = m_dwell[i];
        m_last[i] = win;
      end
    end else if (pre) begin
      e.rdy[0]  = 1'b1;
      m_num[i]  = d[15:0];
      m_src[i]  = 0;
      m_left[i] = m_dwell[i];
      m_last[i] = 0;
    end else begin
      if (v[m_src[i]]) begin
        e.rdy[m_src[i]] = 1'b1;
        m_num[i] = d[16*m_src[i] +: 16];
      end
      m_left[i] = m_left[i] - 1;
      if (m_left[i] == 0) m_show[i] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag, input obs_t e, input obs_t a, input logic [2:0] v);
    check({tag, ".req_ready"}, 16'(a.rdy), 16'(e.rdy));
    check({tag, ".number"}, a.num, e.num);
    check({tag, ".number_valid"}, 16'(a.nv), 16'(e.nv));
    check({tag, ".src"}, 16'(a.src), 16'(e.src));
    check({tag, ".busy"}, 16'(a.busy), 16'(e.busy));
    check({tag, ".ready_onehot0"}, 16'($countones(a.rdy) <= 1), 16'd1);
    check({tag, ".ready_without_valid"}, 16'(a.rdy & ~v), 16'd0);
  endtask

  // Monitor: compares whenever the scoreboard holds a prediction.
  always @(negedge clk100) begin
    obs_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      compare("dwell4", e, {ready_a, number_a, nv_a, src_a, busy_a}, req_valid);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      compare("dwell1", e, {ready_b, number_b, nv_b, src_b, busy_b}, req_valid);
    end
  end

  task automatic cyc(input bit r, input logic [2:0] v, input logic [47:0] d);
    obs_t e;
    reset     = r;
    req_valid = v;
    req_data  = d;
    model_cycle(0, r, v, d, e);
    q_a.push_back(e);
    model_cycle(1, r, v, d, e);
    q_b.push_back(e);
    @(posedge clk100);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] d;
    bit          r;
    m_dwell[0] = 4;
    m_dwell[1] = 1;
    model_reset(0);
    model_reset(1);
    reset     = 1'b1;
    req_valid = 3'b000;
    req_data  = 48'h0;
    @(posedge clk100);
    #1;
    cyc(1'b1, 3'b000, 48'h0);
    cyc(1'b1, 3'b000, 48'h0);

    // All three sources held: sources served 0,1,2 then back to 0.
    repeat (20) cyc(1'b0, 3'b111, 48'h3333_2222_1111);

    // Source 1 refreshes its value mid-dwell.
    cyc(1'b1, 3'b000, 48'h0);
    cyc(1'b0, 3'b010, {16'h0000, 16'hAAAA, 16'h0000});
    cyc(1'b0, 3'b000, 48'h0);
    cyc(1'b0, 3'b010, {16'h0000, 16'hBBBB, 16'h0000});
    repeat (6) cyc(1'b0, 3'b000, 48'h0);

    // Reset during the third display cycle, with a request pending.
    cyc(1'b1, 3'b000, 48'h0);
    cyc(1'b0, 3'b100, 48'h3333_0000_0000);
    cyc(1'b0, 3'b000, 48'h0);
    cyc(1'b0, 3'b000, 48'h0);
    cyc(1'b1, 3'b100, 48'h3333_0000_0000);
    cyc(1'b0, 3'b000, 48'h0);

    // Sources 1 and 2 held together: alternating grants.
    cyc(1'b1, 3'b000, 48'h0);
    repeat (12) begin
      d = {16'($urandom), 32'($urandom)};
      cyc(1'b0, 3'b110, d);
    end

    // Source 0 arriving while source 2 owns the display.
    cyc(1'b1, 3'b000, 48'h0);
    cyc(1'b0, 3'b100, 48'h3333_0000_0000);
    cyc(1'b0, 3'b101, 48'h3333_0000_DEAD);
    repeat (6) cyc(1'b0, 3'b001, 48'h0000_0000_DEAD);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      r = ($urandom_range(0, 63) == 0);
      d = {16'($urandom), 32'($urandom)};
      cyc(r, 3'($urandom_range(0, 7)), d);
    end

    cyc(1'b0, 3'b000, 48'h0);
    @(negedge clk100);
    #1;
    check("scoreboard_drained", 16'(q_a.size() + q_b.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
